// File: rtl/parking_pkg.sv
// Shared constants, types and the capacity schedule
// for the campus parking-lot occupancy controller.
package parking_pkg;

    localparam int TOTAL_SPACES    = 700;
    localparam int UNI_CAP_OFFPEAK = 200;
    localparam int UNI_CAP_PEAK    = 500;
    localparam int CAP_STEP        = 50;

    localparam int PEAK_START  = 8;
    localparam int TAPER_START = 13;
    localparam int TAPER_END   = 16;

    localparam int MIN_PER_HOUR = 60;
    localparam int MIN_PER_DAY  = 1440;

    typedef logic signed [10:0] count_t;
    typedef logic [4:0]         hour_t;
    typedef logic [10:0]        minute_t;

    // University share of the lot for a given hour of day.
    // The taper loses CAP_STEP spaces per hour after peak.
    function automatic count_t uni_cap(hour_t h);
        int hr;
        hr = int'(h);
        if (hr < PEAK_START || hr >= TAPER_END)
            return count_t'(UNI_CAP_OFFPEAK);
        if (hr < TAPER_START)
            return count_t'(UNI_CAP_PEAK);
        return count_t'(UNI_CAP_PEAK
            - CAP_STEP * (hr - TAPER_START + 1));
    endfunction

endpackage

// File: rtl/parking_clock.sv
// Time-of-day keeper: cycles per minute, minutes
// per day, and the derived hour.
module parking_clock
    import parking_pkg::*;
#(
    parameter int CYCLES_PER_MIN = 60
) (
    input  logic  clk,
    input  logic  rst_n,
    output hour_t hour_o
);

    localparam int CW =
        (CYCLES_PER_MIN > 1) ? $clog2(CYCLES_PER_MIN) : 1;
    localparam logic [CW-1:0] CYC_LAST =
        CW'(CYCLES_PER_MIN - 1);
    localparam minute_t MIN_LAST =
        minute_t'(MIN_PER_DAY - 1);

    logic [CW-1:0] cyc_q;
    minute_t       min_q;

    // Advance the minute once per CYCLES_PER_MIN cycles,
    // wrapping at midnight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q <= '0;
            min_q <= '0;
        end else if (cyc_q == CYC_LAST) begin
            cyc_q <= '0;
            if (min_q == MIN_LAST)
                min_q <= '0;
            else
                min_q <= min_q + minute_t'(1);
        end else begin
            cyc_q <= cyc_q + CW'(1);
        end
    end

    minute_t hour_w;
    assign hour_w = min_q / minute_t'(MIN_PER_HOUR);
    assign hour_o = hour_w[4:0];

endmodule

// File: rtl/parking.sv
// Parking occupancy controller: per-class counts,
// time-of-day capacity split, free-space reporting.
module parking
    import parking_pkg::*;
#(
    parameter int CYCLES_PER_MIN = 60,
    parameter int TOTAL_SPACES   = 700
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic signed [10:0] uni_parked_car,
    output logic signed [10:0] parked_car,
    output logic signed [10:0] uni_vacated_space,
    output logic signed [10:0] vacated_space,
    output logic               uni_is_vacated_space,
    output logic               is_vacated_space,
    input  logic               car_entered,
    input  logic               is_uni_car_entered,
    input  logic               car_exited,
    input  logic               is_uni_car_exited
);

    hour_t  hour;
    count_t uni_cap_w;
    count_t nu_cap_w;
    count_t uni_q, uni_d;
    count_t nu_q, nu_d;
    logic   uni_in, uni_out;
    logic   nu_in, nu_out;

    parking_clock #(
        .CYCLES_PER_MIN(CYCLES_PER_MIN)
    ) u_clock (
        .clk   (clk),
        .rst_n (rst_n),
        .hour_o(hour)
    );

    assign uni_cap_w = uni_cap(hour);
    assign nu_cap_w  = count_t'(TOTAL_SPACES) - uni_cap_w;

    // Accept decisions use the counts held at cycle start;
    // same-class entry and exit simply net out.
    always_comb begin
        uni_in  = car_entered && is_uni_car_entered
                  && (uni_q < uni_cap_w);
        uni_out = car_exited && is_uni_car_exited
                  && (uni_q > count_t'(0));
        nu_in   = car_entered && !is_uni_car_entered
                  && (nu_q < nu_cap_w);
        nu_out  = car_exited && !is_uni_car_exited
                  && (nu_q > count_t'(0));
        uni_d   = uni_q + count_t'(uni_in)
                  - count_t'(uni_out);
        nu_d    = nu_q + count_t'(nu_in)
                  - count_t'(nu_out);
    end

    // Occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uni_q <= '0;
            nu_q  <= '0;
        end else begin
            uni_q <= uni_d;
            nu_q  <= nu_d;
        end
    end

    assign uni_parked_car    = uni_q;
    assign parked_car        = nu_q;
    assign uni_vacated_space = uni_cap_w - uni_q;
    assign vacated_space     = nu_cap_w - nu_q;

    assign uni_is_vacated_space =
        (uni_vacated_space > 11'sd0);
    assign is_vacated_space =
        (vacated_space > 11'sd0);

endmodule

// File: tb/tb_parking.sv
// Randomized and directed bench for parking, checked
// against a schedule-table occupancy model.
module tb_parking;

    localparam int CPM = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic signed [10:0] uni_parked_car;
    logic signed [10:0] parked_car;
    logic signed [10:0] uni_vacated_space;
    logic signed [10:0] vacated_space;
    logic uni_is_vacated_space;
    logic is_vacated_space;
    logic car_entered = 1'b0;
    logic is_uni_car_entered = 1'b0;
    logic car_exited = 1'b0;
    logic is_uni_car_exited = 1'b0;

    parking #(
        .CYCLES_PER_MIN(CPM),
        .TOTAL_SPACES  (700)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .uni_parked_car      (uni_parked_car),
        .parked_car          (parked_car),
        .uni_vacated_space   (uni_vacated_space),
        .vacated_space       (vacated_space),
        .uni_is_vacated_space(uni_is_vacated_space),
        .is_vacated_space    (is_vacated_space),
        .car_entered         (car_entered),
        .is_uni_car_entered  (is_uni_car_entered),
        .car_exited          (car_exited),
        .is_uni_car_exited   (is_uni_car_exited)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    int m_uni, m_nu, m_cyc, m_min;
    int ucap_tbl[24];

    task automatic check(string tag, int got, int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d t=%0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic int m_hour();
        return m_min / 60;
    endfunction

    task automatic model_reset();
        m_uni = 0;
        m_nu  = 0;
        m_cyc = 0;
        m_min = 0;
    endtask

    task automatic check_all();
        int uc, fc;
        uc = ucap_tbl[m_hour()];
        fc = 700 - uc;
        check("uni_cnt", int'(uni_parked_car), m_uni);
        check("nu_cnt", int'(parked_car), m_nu);
        check("uni_vac", int'(uni_vacated_space),
              uc - m_uni);
        check("nu_vac", int'(vacated_space), fc - m_nu);
        check("uni_flag", int'(uni_is_vacated_space),
              (uc - m_uni > 0) ? 1 : 0);
        check("nu_flag", int'(is_vacated_space),
              (fc - m_nu > 0) ? 1 : 0);
    endtask

    task automatic model_edge(bit e, bit eu, bit x, bit xu);
        int uc, fc, du, dn;
        uc = ucap_tbl[m_hour()];
        fc = 700 - uc;
        du = 0;
        dn = 0;
        if (e && eu && m_uni < uc) du++;
        if (e && !eu && m_nu < fc) dn++;
        if (x && xu && m_uni > 0) du--;
        if (x && !xu && m_nu > 0) dn--;
        m_uni += du;
        m_nu  += dn;
        m_cyc++;
        if (m_cyc == CPM) begin
            m_cyc = 0;
            m_min = (m_min + 1) % 1440;
        end
    endtask

    // Called and returning at a falling edge.
    task automatic step(bit e, bit eu, bit x, bit xu);
        check_all();
        car_entered        = e;
        is_uni_car_entered = eu;
        car_exited         = x;
        is_uni_car_exited  = xu;
        @(posedge clk);
        model_edge(e, eu, x, xu);
        @(negedge clk);
    endtask

    task automatic repeat_step(int n, bit e, bit eu,
                               bit x, bit xu);
        for (int i = 0; i < n; i++) step(e, eu, x, xu);
    endtask

    task automatic idle_until_hour(int h);
        int n;
        n = 0;
        while (m_hour() != h && n < 3000) begin
            step(0, 0, 0, 0);
            n++;
        end
        check("hour_reached", m_hour(), h);
    endtask

    task automatic rand_steps(int n);
        for (int i = 0; i < n; i++)
            step($urandom_range(0, 99) < 65,
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, 99) < 40,
                 $urandom_range(0, 1) == 1);
    endtask

    initial begin
        for (int h = 0; h < 24; h++) begin
            if (h < 8 || h >= 16)  ucap_tbl[h] = 200;
            else if (h < 13)       ucap_tbl[h] = 500;
            else                   ucap_tbl[h] = 500 - 50 * (h - 12);
        end
        model_reset();

        #7;
        check("rst_uni", int'(uni_parked_car), 0);
        check("rst_nu", int'(parked_car), 0);
        check("rst_uvac", int'(uni_vacated_space), 200);
        check("rst_vac", int'(vacated_space), 500);
        check("rst_uflag", int'(uni_is_vacated_space), 1);
        check("rst_flag", int'(is_vacated_space), 1);

        @(negedge clk);
        rst_n = 1'b1;

        repeat_step(201, 1, 1, 0, 0);
        check("uni_full", int'(uni_parked_car), 200);
        check("uni_full_vac",
              int'(uni_vacated_space), 0);
        check("uni_full_flag",
              int'(uni_is_vacated_space), 0);

        step(1, 1, 1, 1);
        check("uni_net", int'(uni_parked_car), 199);
        step(0, 0, 1, 0);
        step(1, 0, 1, 0);
        check("nu_net", int'(parked_car), 1);

        repeat_step(500, 1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 0, 1, 0);

        repeat_step(198, 0, 0, 1, 1);
        repeat_step(5, 1, 0, 0, 0);
        idle_until_hour(8);
        step(1, 0, 0, 0);
        repeat_step(300, 1, 1, 0, 0);
        repeat_step(300, 0, 0, 1, 0);
        repeat_step(300, 1, 1, 0, 0);

        idle_until_hour(13);
        idle_until_hour(14);
        idle_until_hour(15);
        idle_until_hour(16);

        repeat_step(300, 0, 0, 1, 1);
        repeat_step(200, 0, 0, 1, 0);
        repeat_step(200, 0, 0, 1, 1);
        check("drain_uni", int'(uni_parked_car), 0);
        check("drain_nu", int'(parked_car), 0);
        check("drain_uvac", int'(uni_vacated_space), 200);
        check("drain_vac", int'(vacated_space), 500);
        check("drain_flags",
              int'({uni_is_vacated_space,
                    is_vacated_space}), 3);

        rand_steps(4000);

        rst_n = 1'b0;
        #1;
        check("mid_rst_uni", int'(uni_parked_car), 0);
        check("mid_rst_nu", int'(parked_car), 0);
        check("mid_rst_uvac", int'(uni_vacated_space), 200);
        check("mid_rst_vac", int'(vacated_space), 500);
        model_reset();
        car_entered = 1'b1;
        car_exited  = 1'b1;
        @(negedge clk);
        car_entered = 1'b0;
        car_exited  = 1'b0;
        rst_n = 1'b1;

        rand_steps(1500);
        check_all();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
